// File: rtl/fetch_queue_unit.sv
// Instruction fetch front end: PC owner, 1-cycle imem, DEPTH-entry queue.
// Optional FETCH_BYPASS_EN forwards a response straight to decode when empty.
module fetch_queue_unit #(
  parameter int                 ADDR_W   = 64,
  parameter int                 INSTR_W  = 32,
  parameter int                 DEPTH    = 4,
  parameter logic [ADDR_W-1:0]  RESET_PC = '0
) (
  input  logic                       clk,
  input  logic                       reset,
  output logic                       imem_req,
  output logic [ADDR_W-1:0]          imem_addr,
  input  logic [INSTR_W-1:0]         imem_rdata,
  input  logic                       redirect,
  input  logic [ADDR_W-1:0]          redirect_pc,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [INSTR_W-1:0]         out_instr,
  output logic [ADDR_W-1:0]          out_pc,
  output logic [ADDR_W-1:0]          out_pc_plus4,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [ADDR_W-1:0]  pc_q, pc_d;
  logic [ADDR_W-1:0]  rpc_q, rpc_d;
  logic               pend_q, pend_d;
  logic               hv_q, hv_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [PW-1:0]      rd_q, rd_d;
  logic [PW-1:0]      wr_q, wr_d;

  logic [INSTR_W-1:0] mem_instr_q [DEPTH];
  logic [ADDR_W-1:0]  mem_pc_q    [DEPTH];

  logic [CW:0]        used;
  logic               head_valid;
  logic               byp;
  logic               push;
  logic               pop;

  // Credit counts the in-flight response so the queue can never overflow.
  assign used       = {1'b0, cnt_q} + (CW+1)'(pend_q);
  assign imem_req   = ~reset & ~redirect & (used < (CW+1)'(DEPTH));
  assign imem_addr  = pc_q;
  assign head_valid = (cnt_q != '0);
  assign count      = cnt_q;

`ifdef FETCH_BYPASS_EN
  assign byp = ~head_valid & pend_q & ~redirect;
`else
  assign byp = 1'b0;
`endif

  assign out_valid = head_valid | byp;
  assign out_instr = byp ? imem_rdata : mem_instr_q[rd_q];
  assign out_pc    = byp ? rpc_q : mem_pc_q[rd_q];

  // Reads zero until a head has ever been presented.
  assign out_pc_plus4 = (hv_q | out_valid) ? out_pc + ADDR_W'(4) : '0;

  assign pop  = head_valid & out_ready & ~redirect;
  assign push = pend_q & ~redirect & ~(byp & out_ready);

  always_comb begin
    pc_d   = pc_q;
    rpc_d  = rpc_q;
    pend_d = imem_req;
    hv_d   = hv_q | out_valid;
    rd_d   = rd_q;
    wr_d   = wr_q;
    cnt_d  = cnt_q;
    if (redirect) begin
      pc_d  = redirect_pc;
      rd_d  = '0;
      wr_d  = '0;
      cnt_d = '0;
    end else begin
      if (imem_req) begin
        pc_d  = pc_q + ADDR_W'(4);
        rpc_d = pc_q;
      end
      if (pop)  rd_d = rd_q + PW'(1);
      if (push) wr_d = wr_q + PW'(1);
      cnt_d = cnt_q + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q   <= RESET_PC;
      rpc_q  <= RESET_PC;
      pend_q <= 1'b0;
      hv_q   <= 1'b0;
      cnt_q  <= '0;
      rd_q   <= '0;
      wr_q   <= '0;
    end else begin
      pc_q   <= pc_d;
      rpc_q  <= rpc_d;
      pend_q <= pend_d;
      hv_q   <= hv_d;
      cnt_q  <= cnt_d;
      rd_q   <= rd_d;
      wr_q   <= wr_d;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_instr_q[i] <= '0;
        mem_pc_q[i]    <= '0;
      end
    end else if (push) begin
      mem_instr_q[wr_q] <= imem_rdata;
      mem_pc_q[wr_q]    <= rpc_q;
    end
  end

`ifndef SYNTHESIS
  always_ff @(posedge clk) begin
    if (!reset) begin
      assert (!(push && cnt_q == CW'(DEPTH)));
    end
  end
`endif

endmodule

// File: tb/tb_fetch_queue_unit.sv
// Directed bench for fetch_queue_unit with a request/pop scoreboard.
module tb_fetch_queue_unit;

  localparam int AW = 64;
  localparam int IW = 32;
  localparam int D  = 4;
  localparam int CW = 3;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          imem_req;
  logic [AW-1:0] imem_addr;
  logic [IW-1:0] imem_rdata = '0;
  logic          redirect = 1'b0;
  logic [AW-1:0] redirect_pc = '0;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [IW-1:0] out_instr;
  logic [AW-1:0] out_pc;
  logic [AW-1:0] out_pc_plus4;
  logic [CW-1:0] count;

  int total = 0;
  int bad   = 0;
  logic [AW-1:0] exp_q [$];

  fetch_queue_unit #(
    .ADDR_W(AW), .INSTR_W(IW), .DEPTH(D), .RESET_PC('0)
  ) dut (
    .clk(clk), .reset(reset),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_rdata(imem_rdata),
    .redirect(redirect), .redirect_pc(redirect_pc),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_instr(out_instr), .out_pc(out_pc),
    .out_pc_plus4(out_pc_plus4), .count(count)
  );

  always #5 clk = ~clk;

  // Instruction memory: fixed 1-cycle latency, data = 0x91000000 + addr.
  always @(posedge clk) imem_rdata <= 32'h9100_0000 + imem_addr[31:0];

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    logic [AW-1:0] e;
    if (reset || redirect) begin
      exp_q.delete();
    end else begin
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          chk("sb_extra_pop", 64'(exp_q.size()), 64'd1);
        end else begin
          e = exp_q.pop_front();
          chk("sb_pc", out_pc, e);
          chk("sb_instr", 64'(out_instr), 64'(32'h9100_0000 + e[31:0]));
          chk("sb_plus4", out_pc_plus4, e + 64'd4);
        end
      end
      if (imem_req) exp_q.push_back(imem_addr);
      chk("cnt_bound", 64'(count <= CW'(D)), 64'd1);
    end
  end

  initial begin
    int n;
    #2;
    chk("rst_valid", 64'(out_valid), 64'd0);
    chk("rst_count", 64'(count), 64'd0);
    chk("rst_req", 64'(imem_req), 64'd0);
    chk("rst_addr", imem_addr, 64'd0);
    chk("rst_instr", 64'(out_instr), 64'd0);
    chk("rst_pc", out_pc, 64'd0);
    chk("rst_plus4", out_pc_plus4, 64'd0);

    tick();
    tick();
    reset = 1'b0;
    #1;
    chk("req_release", 64'(imem_req), 64'd1);
    tick();
`ifdef FETCH_BYPASS_EN
    chk("byp_valid", 64'(out_valid), 64'd1);
    chk("byp_pc0", out_pc, 64'd0);
    chk("byp_cnt0", 64'(count), 64'd0);
    tick();
    chk("byp_pc1", out_pc, 64'd4);
    chk("byp_cnt1", 64'(count), 64'd0);
`else
    chk("lat_v0", 64'(out_valid), 64'd0);
    tick();
    chk("lat_v1", 64'(out_valid), 64'd1);
    chk("seq_pc0", out_pc, 64'd0);
    chk("seq_p4_0", out_pc_plus4, 64'd4);
    tick();
    chk("seq_pc4", out_pc, 64'd4);
    tick();
    chk("seq_pc8", out_pc, 64'd8);
    tick();
    chk("seq_pc12", out_pc, 64'd12);
`endif

    out_ready = 1'b0;
    repeat (10) tick();
    chk("stall_cnt", 64'(count), 64'(D));
    chk("stall_req", 64'(imem_req), 64'd0);
    chk("stall_valid", 64'(out_valid), 64'd1);
    out_ready = 1'b1;
    repeat (8) tick();

    out_ready = 1'b0;
    n = 0;
    while (count != CW'(3) && n < 20) begin
      tick();
      n++;
    end
    chk("fill3_cnt", 64'(count), 64'd3);
    chk("fill3_req", 64'(imem_req), 64'd0);
    redirect    = 1'b1;
    redirect_pc = 64'h40;
    #1;
    chk("redir_req", 64'(imem_req), 64'd0);
    tick();
    redirect  = 1'b0;
    out_ready = 1'b1;
    #1;
    chk("redir_cnt", 64'(count), 64'd0);
    chk("redir_valid", 64'(out_valid), 64'd0);
    chk("redir_addr", imem_addr, 64'h40);
    chk("redir_req1", 64'(imem_req), 64'd1);
    tick();
    chk("stale_cnt", 64'(count), 64'd0);
`ifdef FETCH_BYPASS_EN
    chk("redir_byp_v", 64'(out_valid), 64'd1);
    chk("redir_byp_pc", out_pc, 64'h40);
`else
    chk("stale_valid", 64'(out_valid), 64'd0);
    tick();
    chk("redir_head_v", 64'(out_valid), 64'd1);
    chk("redir_head_pc", out_pc, 64'h40);
`endif
    repeat (5) tick();

    redirect    = 1'b1;
    redirect_pc = 64'h40;
    tick();
    redirect_pc = 64'h80;
    tick();
    redirect = 1'b0;
    #1;
    n = 0;
    while (!out_valid && n < 10) begin
      tick();
      n++;
    end
    chk("b2b_valid", 64'(out_valid), 64'd1);
    chk("b2b_pc", out_pc, 64'h80);
    repeat (4) tick();

    out_ready = 1'b0;
    repeat (8) tick();
    chk("full_cnt", 64'(count), 64'(D));
    #1;
    reset = 1'b1;
    #1;
    chk("arst_valid", 64'(out_valid), 64'd0);
    chk("arst_cnt", 64'(count), 64'd0);
    chk("arst_addr", imem_addr, 64'd0);
    chk("arst_req", 64'(imem_req), 64'd0);
    chk("arst_plus4", out_pc_plus4, 64'd0);
    tick();
    tick();
    out_ready = 1'b1;
    reset = 1'b0;
    repeat (12) tick();
    chk("end_valid", 64'(out_valid), 64'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
